trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences exception entry, interrupt entry and ERET through the PCR file's single trap write port.
//  Sits between the pipeline's exception/retire logic and the control processor.
//  Takes one trap event at a time, writes EPC/CAUSE/BADVADDR/STATUS one per cycle, then redirects fetch.
//  Holds the pipeline busy for the whole sequence.
// PARAMETERS
//  RESET_VEC  32'h0000_2000  redirect target used when evec_in==0 (EVEC never programmed)
//  NUM_IRQ    8              interrupt lines; line n is masked by status bit IM[16+n]
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, synchronous, active-high
//  stall         in   1   memory stall; freezes FSM and suppresses wr_en/redirect_valid
//  exc_valid     in   1   synchronous exception from the commit stage
//  exc_cause     in   5   exception cause code
//  exc_pc        in   32  PC of the faulting instruction
//  exc_has_addr  in   1   exception carries a bad virtual address
//  exc_badvaddr  in   32  faulting address
//  eret          in   1   ERET committing this cycle
//  irq           in   NUM_IRQ  level-sensitive interrupt lines
//  irq_pc        in   32  PC to resume at after an interrupt
//  status_in     in   32  current STATUS PCR value
//  evec_in       in   32  current EVEC PCR value
//  epc_in        in   32  current EPC PCR value
//  wr_en         out  1   PCR trap-port write strobe
//  wr_pcr        out  5   PCR address: STATUS=0, EPC=1, BADVADDR=2, CAUSE=6
//  wr_data       out  32  PCR write data
//  redirect_valid out 1   one-cycle fetch redirect
//  redirect_pc   out  32  redirect target
//  busy          out  1   high whenever state!=IDLE; pipeline must not issue
//  fatal         out  1   exception taken with ET=0; sticky until reset
// BEHAVIOUR
//  STATUS bits: ET=0, EF=1, EV=2, EC=3, PS=4, S=5, U64=6, S64=7, VM=8, IM=23:16.
//  Reset: state=IDLE; every output 0; all latches 0.
//  FSM states: IDLE, W_EPC, W_CAUSE, W_BADV, W_STAT, E_STAT, REDIR, ERROR.
//  Accept in IDLE only, when !stall. Priority: exc_valid > irq > eret.
//  Pending irq = |(irq & status_in[16+:NUM_IRQ]) && status_in[ET].
//  Exception, ET=1: latch pc/cause/badvaddr/has_addr -> W_EPC.
//  Exception, ET=0: -> ERROR. fatal=1, busy=1, no writes; ERROR is left only by reset.
//  Interrupt: cause = 32'h8000_0000 | n, n = lowest-index pending line; pc=irq_pc; has_addr=0 -> W_EPC.
//  W_EPC: wr EPC=pc -> W_CAUSE.
//  W_CAUSE: wr CAUSE = {27'b0,cause} for exceptions, latched word for interrupts.
//    Next: W_BADV if has_addr, else W_STAT.
//  W_BADV: wr BADVADDR -> W_STAT.
//  W_STAT: wr STATUS = status_in with PS<=S, S<=1, ET<=0 (other bits unchanged) -> REDIR.
//    Target = (evec_in==0) ? RESET_VEC : evec_in.
//  ERET: latch target=epc_in -> E_STAT.
//  E_STAT: wr STATUS = status_in with S<=PS, ET<=1 -> REDIR.
//  REDIR: redirect_valid=1 with redirect_pc=target for exactly one cycle -> IDLE.
//  Latency: exception without address = 4 cycles accept->redirect pulse; with address = 5; ERET = 2.
//  Any state with stall=1: state holds, wr_en=0, redirect_valid=0; writes/redirect resume when stall drops.
//  exc_valid/irq/eret while busy are ignored; the pipeline guarantees retention.
//  Exactly one wr_en per write state; wr_pcr/wr_data are 0 when wr_en=0.
//  Reset mid-sequence: immediate return to IDLE; partial PCR writes already made are not undone.
// TESTING
//  1. STATUS=0x21, exc cause=5 pc=0x100 has_addr=1 badv=0xDEAD, EVEC=0x400
//     -> writes EPC=0x100, CAUSE=5, BADVADDR=0xDEAD, STATUS=0x30; redirect 0x400 on cycle 5.
//  2. STATUS=0x00010021, irq=0x03, irq_pc=0x200
//     -> CAUSE=0x80000000, no BADVADDR write, STATUS=0x00010030, redirect on cycle 4.
//  3. STATUS=0x30, EPC=0x104, eret -> STATUS write=0x21; redirect_pc=0x104 on cycle 2.
//  4. exc and eret in the same cycle -> trap sequence only.
//     Stall held 3 cycles in W_CAUSE -> CAUSE write delayed 3 cycles, no duplicate writes.
//  5. STATUS=0x20 (ET=0), exc_valid -> fatal=1, busy=1, no wr_en ever; reset clears both.
//  6. EVEC=0, exc without address -> redirect 32'h2000.
//     Reset asserted in W_CAUSE -> next cycle IDLE, outputs 0.

Source files
------------

// File: rtl/trap_if.sv
// Trap-sequencer bus: pipeline/PCR-file inputs and PCR trap-port/redirect outputs.
// Handshake: the sequencer takes an event only when it is idle and stall is low.
// busy acts as its not-ready, and the pipeline holds an event until busy drops.
interface trap_if #(
  parameter int NUM_IRQ = 8
);
  logic               stall;
  logic               exc_valid;
  logic [4:0]         exc_cause;
  logic [31:0]        exc_pc;
  logic               exc_has_addr;
  logic [31:0]        exc_badvaddr;
  logic               eret;
  logic [NUM_IRQ-1:0] irq;
  logic [31:0]        irq_pc;
  logic [31:0]        status_in;
  logic [31:0]        evec_in;
  logic [31:0]        epc_in;
  logic               wr_en;
  logic [4:0]         wr_pcr;
  logic [31:0]        wr_data;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               busy;
  logic               fatal;

  modport master (
    output stall, exc_valid, exc_cause, exc_pc, exc_has_addr, exc_badvaddr,
           eret, irq, irq_pc, status_in, evec_in, epc_in,
    input  wr_en, wr_pcr, wr_data, redirect_valid, redirect_pc, busy, fatal
  );

  modport slave (
    input  stall, exc_valid, exc_cause, exc_pc, exc_has_addr, exc_badvaddr,
           eret, irq, irq_pc, status_in, evec_in, epc_in,
    output wr_en, wr_pcr, wr_data, redirect_valid, redirect_pc, busy, fatal
  );
endinterface

// File: rtl/trap_sequencer.sv
// Sequences exception/interrupt entry and ERET through the PCR trap write port,
// one PCR write per cycle, followed by a single-cycle fetch redirect.
module trap_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_2000,
  parameter int          NUM_IRQ   = 8
) (
  input  logic       clk,
  input  logic       reset,
  trap_if.slave      tif,
  output logic [2:0] dbg_state_o
);

  localparam logic [4:0] PCR_STATUS = 5'd0;
  localparam logic [4:0] PCR_EPC    = 5'd1;
  localparam logic [4:0] PCR_BADV   = 5'd2;
  localparam logic [4:0] PCR_CAUSE  = 5'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_W_EPC, S_W_CAUSE, S_W_BADV, S_W_STAT, S_E_STAT, S_REDIR, S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] badv_q, badv_d;
  logic        has_addr_q, has_addr_d;
  logic [31:0] target_q, target_d;

  logic [NUM_IRQ-1:0] irq_pend;
  logic               irq_take;
  logic [4:0]         irq_n;

  // Lowest-index pending line wins; nothing is pending while ET is clear.
  always_comb begin
    irq_pend = tif.irq & tif.status_in[16 +: NUM_IRQ];
    irq_take = (|irq_pend) && tif.status_in[0];
    irq_n    = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_n = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cause_q    <= '0;
      badv_q     <= '0;
      has_addr_q <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cause_q    <= cause_d;
      badv_q     <= badv_d;
      has_addr_q <= has_addr_d;
      target_q   <= target_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    badv_d     = badv_q;
    has_addr_d = has_addr_q;
    target_d   = target_q;
    if (!tif.stall) begin
      unique case (state_q)
        S_IDLE: begin
          if (tif.exc_valid) begin
            if (tif.status_in[0]) begin
              pc_d       = tif.exc_pc;
              cause_d    = {27'b0, tif.exc_cause};
              badv_d     = tif.exc_badvaddr;
              has_addr_d = tif.exc_has_addr;
              state_d    = S_W_EPC;
            end else begin
              state_d = S_ERROR;
            end
          end else if (irq_take) begin
            pc_d       = tif.irq_pc;
            cause_d    = 32'h8000_0000 | {27'b0, irq_n};
            has_addr_d = 1'b0;
            state_d    = S_W_EPC;
          end else if (tif.eret) begin
            target_d = tif.epc_in;
            state_d  = S_E_STAT;
          end
        end
        S_W_EPC:   state_d = S_W_CAUSE;
        S_W_CAUSE: state_d = has_addr_q ? S_W_BADV : S_W_STAT;
        S_W_BADV:  state_d = S_W_STAT;
        S_W_STAT: begin
          target_d = (tif.evec_in == 32'd0) ? RESET_VEC : tif.evec_in;
          state_d  = S_REDIR;
        end
        S_E_STAT:  state_d = S_REDIR;
        S_REDIR:   state_d = S_IDLE;
        S_ERROR:   state_d = S_ERROR;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tif.wr_en          = 1'b0;
    tif.wr_pcr         = 5'd0;
    tif.wr_data        = 32'd0;
    tif.redirect_valid = 1'b0;
    tif.redirect_pc    = 32'd0;
    tif.busy           = (state_q != S_IDLE);
    tif.fatal          = (state_q == S_ERROR);
    if (!tif.stall) begin
      unique case (state_q)
        S_W_EPC: begin
          tif.wr_en   = 1'b1;
          tif.wr_pcr  = PCR_EPC;
          tif.wr_data = pc_q;
        end
        S_W_CAUSE: begin
          tif.wr_en   = 1'b1;
          tif.wr_pcr  = PCR_CAUSE;
          tif.wr_data = cause_q;
        end
        S_W_BADV: begin
          tif.wr_en   = 1'b1;
          tif.wr_pcr  = PCR_BADV;
          tif.wr_data = badv_q;
        end
        S_W_STAT: begin
          tif.wr_en   = 1'b1;
          tif.wr_pcr  = PCR_STATUS;
          tif.wr_data = {tif.status_in[31:6], 1'b1, tif.status_in[5],
                         tif.status_in[3:1], 1'b0};
        end
        // ERET restores S from PS and clears PS so a nested return cannot re-enter supervisor.
        S_E_STAT: begin
          tif.wr_en   = 1'b1;
          tif.wr_pcr  = PCR_STATUS;
          tif.wr_data = {tif.status_in[31:6], tif.status_in[4], 1'b0,
                         tif.status_in[3:1], 1'b1};
        end
        S_REDIR: begin
          tif.redirect_valid = 1'b1;
          tif.redirect_pc    = target_q;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Table-driven and randomized checks of trap_sequencer against a write-list model.
module tb_trap_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  trap_if #(.NUM_IRQ(8)) tif ();

  trap_sequencer #(.RESET_VEC(32'h0000_2000), .NUM_IRQ(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .tif         (tif),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] pc;
    logic        has_addr;
    logic [31:0] badv;
    logic        eret;
    logic [7:0]  irq;
    logic [31:0] irq_pc;
    logic [31:0] status;
    logic [31:0] evec;
    logic [31:0] epc;
    logic [15:0] stall_mask;
    logic [31:0] exp_redir;
    int          exp_lat;   // -1 fatal, 0 nothing taken
  } vec_t;

  logic [36:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_inputs();
    tif.stall = 1'b0; tif.exc_valid = 1'b0; tif.exc_cause = '0; tif.exc_pc = '0;
    tif.exc_has_addr = 1'b0; tif.exc_badvaddr = '0; tif.eret = 1'b0; tif.irq = '0;
    tif.irq_pc = '0; tif.status_in = '0; tif.evec_in = '0; tif.epc_in = '0;
  endtask

  // Reference: the list of PCR writes and the redirect that the event must produce.
  task automatic model(input vec_t v, output logic [31:0] redir, output int lat);
    int    line;
    logic [31:0] st;
    st = v.status;
    line = -1;
    for (int i = 7; i >= 0; i--)
      if (v.irq[i] && st[16+i]) line = i;
    exp_q.delete();
    redir = 32'd0;
    lat   = 0;
    if (v.exc || (line >= 0 && st[0])) begin
      if (v.exc && !st[0]) begin
        lat = -1;
      end else begin
        exp_q.push_back({5'd1, v.exc ? v.pc : v.irq_pc});
        exp_q.push_back({5'd6, v.exc ? {27'd0, v.cause} : (32'h8000_0000 + line)});
        if (v.exc && v.has_addr) exp_q.push_back({5'd2, v.badv});
        exp_q.push_back({5'd0, (st & ~32'h31) | 32'h20 | (((st >> 5) & 1) << 4)});
        redir = (v.evec == 0) ? 32'h2000 : v.evec;
        lat   = (v.exc && v.has_addr) ? 5 : 4;
      end
    end else if (v.eret) begin
      exp_q.push_back({5'd0, (st & ~32'h31) | (((st >> 4) & 1) << 5) | 32'h1});
      redir = v.epc;
      lat   = 2;
    end
  endtask

  task automatic run_event(input vec_t v, input logic [31:0] exp_redir, input int exp_lat);
    int cyc, active;
    logic done;
    logic [36:0] e;
    @(posedge clk); #1;
    tif.stall = 1'b0; tif.exc_valid = v.exc; tif.exc_cause = v.cause; tif.exc_pc = v.pc;
    tif.exc_has_addr = v.has_addr; tif.exc_badvaddr = v.badv; tif.eret = v.eret;
    tif.irq = v.irq; tif.irq_pc = v.irq_pc; tif.status_in = v.status;
    tif.evec_in = v.evec; tif.epc_in = v.epc;
    #1;
    check("accept_quiet", {tif.busy, tif.wr_en, tif.redirect_valid}, 3'b000);
    @(posedge clk); #1;
    tif.exc_valid = 1'b0; tif.eret = 1'b0; tif.irq = '0;
    if (exp_lat < 0) begin
      repeat (4) begin
        #1;
        check("fatal_hold", {tif.fatal, tif.busy, tif.wr_en, tif.redirect_valid}, 4'b1100);
        @(posedge clk); #1;
      end
      do_reset();
      #1;
      check("fatal_cleared", {tif.fatal, tif.busy}, 2'b00);
    end else if (exp_lat == 0) begin
      #1;
      check("no_event", {tif.busy, tif.wr_en, tif.redirect_valid}, 3'b000);
    end else begin
      cyc = 1; active = 0; done = 1'b0;
      while (!done && cyc <= 40) begin
        tif.stall = (cyc < 16) ? v.stall_mask[cyc] : 1'b0;
        #1;
        check("busy_in_seq", tif.busy, 1'b1);
        if (tif.stall) begin
          check("stall_quiet", {tif.wr_en, tif.redirect_valid}, 2'b00);
        end else begin
          active++;
          if (tif.wr_en) begin
            if (exp_q.size() == 0) begin
              check("extra_write", {tif.wr_pcr, tif.wr_data}, 37'h1F_FFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("pcr_write", {tif.wr_pcr, tif.wr_data}, e);
            end
          end else begin
            check("idle_write_bus", {tif.wr_pcr, tif.wr_data}, 37'd0);
          end
          if (tif.redirect_valid) begin
            check("redirect_pc", tif.redirect_pc, exp_redir);
            check("redirect_latency", active, exp_lat);
            done = 1'b1;
          end
        end
        if (!done) begin
          @(posedge clk); #1;
          cyc++;
        end
      end
      if (!done) check("redirect_timeout", 1'b0, 1'b1);
      tif.stall = 1'b0;
      @(posedge clk); #2;
      check("back_to_idle", {tif.busy, tif.redirect_valid}, 2'b00);
      check("writes_missing", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  vec_t tbl[10];
  vec_t v;
  logic [31:0] m_redir;
  int m_lat;

  initial begin
    clear_inputs();
    reset = 1'b0;
    do_reset();
    #1;
    check("reset_outputs", {tif.wr_en, tif.wr_pcr, tif.wr_data, tif.redirect_valid,
                            tif.redirect_pc, tif.busy, tif.fatal}, 72'd0);

    tbl[0] = '{1, 5'd5, 32'h100, 1, 32'hDEAD, 0, 8'h00, 32'h0, 32'h21, 32'h400, 32'h0, 16'h0, 32'h400, 5};
    tbl[1] = '{0, 5'd0, 32'h0, 0, 32'h0, 0, 8'h03, 32'h200, 32'h0001_0021, 32'h400, 32'h0, 16'h0, 32'h400, 4};
    tbl[2] = '{0, 5'd0, 32'h0, 0, 32'h0, 1, 8'h00, 32'h0, 32'h30, 32'h400, 32'h104, 16'h0, 32'h104, 2};
    tbl[3] = '{1, 5'd3, 32'h300, 0, 32'h0, 1, 8'h00, 32'h0, 32'h21, 32'h500, 32'h999, 16'h001C, 32'h500, 4};
    tbl[4] = '{1, 5'd4, 32'h80, 0, 32'h0, 0, 8'h00, 32'h0, 32'h20, 32'h400, 32'h0, 16'h0, 32'h0, -1};
    tbl[5] = '{1, 5'd2, 32'h40, 0, 32'h0, 0, 8'h00, 32'h0, 32'h21, 32'h0, 32'h0, 16'h0, 32'h2000, 4};
    tbl[6] = '{0, 5'd0, 32'h0, 0, 32'h0, 0, 8'hFF, 32'h600, 32'h21, 32'h400, 32'h0, 16'h0, 32'h0, 0};
    tbl[7] = '{0, 5'd0, 32'h0, 0, 32'h0, 0, 8'h80, 32'h600, 32'h00FF_0020, 32'h400, 32'h0, 16'h0, 32'h0, 0};
    tbl[8] = '{0, 5'd0, 32'h0, 0, 32'h0, 0, 8'h80, 32'h700, 32'h0080_0021, 32'h1000, 32'h0, 16'h0, 32'h1000, 4};
    tbl[9] = '{0, 5'd0, 32'h0, 0, 32'h0, 1, 8'h00, 32'h0, 32'h11, 32'h400, 32'h44, 16'h0006, 32'h44, 2};

    for (int i = 0; i < 10; i++) begin
      model(tbl[i], m_redir, m_lat);
      run_event(tbl[i], tbl[i].exp_redir, tbl[i].exp_lat);
    end

    // Reset asserted while the CAUSE write is pending.
    @(posedge clk); #1;
    tif.status_in = 32'h21; tif.exc_valid = 1'b1; tif.exc_cause = 5'd7; tif.exc_pc = 32'h500;
    @(posedge clk); #1;
    tif.exc_valid = 1'b0;
    @(posedge clk); #1;
    check("in_w_cause", {tif.busy, tif.wr_en, tif.wr_pcr, tif.wr_data}, {2'b11, 5'd6, 32'd7});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("reset_mid_seq", {tif.busy, tif.wr_en, tif.wr_pcr, tif.wr_data, tif.redirect_valid,
                            tif.redirect_pc, tif.fatal}, 72'd0);

    for (int n = 0; n < 40; n++) begin
      v.exc        = ($urandom_range(0, 2) == 0);
      v.cause      = 5'($urandom_range(0, 31));
      v.pc         = $urandom & 32'hFFFF_FFFC;
      v.has_addr   = 1'($urandom_range(0, 1));
      v.badv       = $urandom;
      v.eret       = 1'($urandom_range(0, 1));
      v.irq        = 8'($urandom_range(0, 255));
      v.irq_pc     = $urandom & 32'hFFFF_FFFC;
      v.status     = $urandom;
      if ($urandom_range(0, 7) != 0) v.status[0] = 1'b1;
      v.evec       = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
      v.epc        = $urandom & 32'hFFFF_FFFC;
      v.stall_mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
      model(v, m_redir, m_lat);
      v.exp_redir  = m_redir;
      v.exp_lat    = m_lat;
      run_event(v, m_redir, m_lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
